// File: rtl/fifo_drain_scheduler_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
package fifo_drain_scheduler_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_drain_scheduler_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module fifo_drain_scheduler_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0]   sum;
  logic [W-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      pos = sum[W-1:0];
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_scheduler.sv
// Drains N_SRC source FIFOs round-robin onto one tagged valid/ready stream,
// using a 2-entry output queue and credit-gated reads.
module fifo_drain_scheduler #(
  parameter int N_SRC     = 4,
  parameter int DATAWIDTH = 8,
  parameter int BURST_W   = 4,
  parameter int SRC_W     = $clog2(N_SRC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [BURST_W-1:0]         cfg_burst,
  input  logic [N_SRC-1:0]           src_empty,
  input  logic [N_SRC*DATAWIDTH-1:0] src_data,
  output logic [N_SRC-1:0]           src_rd_en,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATAWIDTH-1:0]       m_data,
  output logic [SRC_W-1:0]           m_src
);

  import fifo_drain_scheduler_pkg::*;

  state_t               state;
  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     grant;
  logic [BURST_W-1:0]   burst_len;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 inflight;
  logic [SRC_W-1:0]     inflight_src;

  logic [DATAWIDTH-1:0] q_data [2];
  logic [SRC_W-1:0]     q_src  [2];
  logic                 head;
  logic [1:0]           occ;

  logic                 pick_found;
  logic [SRC_W-1:0]     pick_idx;
  logic [SRC_W-1:0]     rd_idx;
  logic [BURST_W-1:0]   cfg_len;
  logic                 pop;
  logic                 push;
  logic                 tail;
  logic                 credit_ok;
  logic                 do_read;
  logic [DATAWIDTH-1:0] push_data;

  fifo_drain_scheduler_rr_pick #(
    .N (N_SRC),
    .W (SRC_W)
  ) u_rr_pick (
    .req   (~src_empty),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = q_data[head];
  assign m_src   = q_src[head];
  assign pop     = m_valid && m_ready;
  assign push    = inflight;
  assign tail    = head ^ occ[0];
  assign cfg_len = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;
  assign rd_idx  = (state == ARB) ? pick_idx : grant;

  // A slot freed by this cycle's pop may be refilled by a read issued now.
  assign credit_ok = en && (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign do_read = !rst && credit_ok &&
                   (((state == ARB) && pick_found) ||
                    ((state == BURST) && !src_empty[grant]));

  always_comb begin
    src_rd_en = '0;
    if (do_read) begin
      src_rd_en[rd_idx] = 1'b1;
    end
  end

  always_comb begin
    push_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (inflight_src == SRC_W'(i)) begin
        push_data = src_data[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight     <= 1'b0;
      inflight_src <= '0;
      q_data[0]    <= '0;
      q_data[1]    <= '0;
      q_src[0]     <= '0;
      q_src[1]     <= '0;
      head         <= 1'b0;
      occ          <= 2'd0;
    end else begin
      inflight     <= do_read;
      inflight_src <= rd_idx;
      if (push) begin
        q_data[tail] <= push_data;
        q_src[tail]  <= inflight_src;
      end
      if (pop) begin
        head <= ~head;
      end
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      grant     <= '0;
      burst_len <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (do_read) begin
            grant     <= pick_idx;
            burst_len <= cfg_len;
            burst_cnt <= BURST_W'(1);
            if (cfg_len == BURST_W'(1)) begin
              rr_ptr <= SRC_W'(rr_next(int'(pick_idx), N_SRC));
            end else begin
              state <= BURST;
            end
          end
        end
        BURST: begin
          // With en low the grant is parked, even if its source runs dry.
          if (en) begin
            if (src_empty[grant]) begin
              rr_ptr <= SRC_W'(rr_next(int'(grant), N_SRC));
              state  <= ARB;
            end else if (credit_ok) begin
              burst_cnt <= burst_cnt + BURST_W'(1);
              if (burst_cnt + BURST_W'(1) == burst_len) begin
                rr_ptr <= SRC_W'(rr_next(int'(grant), N_SRC));
                state  <= ARB;
              end
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Scoreboard bench for fifo_drain_scheduler: directed source contents with
// hand-computed output order, plus timing, backpressure and reset checks.
module tb_fifo_drain_scheduler;

  localparam int N_SRC = 4;
  localparam int DW    = 8;
  localparam int BW    = 4;
  localparam int SW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [BW-1:0]     cfg_burst;
  logic [N_SRC-1:0]  src_empty = '1;
  logic [N_SRC*DW-1:0] src_data = '0;
  logic [N_SRC-1:0]  src_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [SW-1:0]     m_src;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    fifo_q [N_SRC][$];
  logic [SW+DW-1:0] load_q [$];
  logic [SW+DW-1:0] exp_q [$];
  logic [SW+DW-1:0] ld_word;
  logic [SW+DW-1:0] exp_word;
  logic             held = 1'b0;
  logic [SW+DW-1:0] held_word = '0;

  logic [N_SRC-1:0] t1_rd [6] = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
  logic             t1_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  fifo_drain_scheduler #(
    .N_SRC     (N_SRC),
    .DATAWIDTH (DW),
    .BURST_W   (BW),
    .SRC_W     (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_burst (cfg_burst),
    .src_empty (src_empty),
    .src_data  (src_data),
    .src_rd_en (src_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_src     (m_src)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input int src, input logic [DW-1:0] data);
    load_q.push_back({SW'(src), data});
  endtask

  task automatic expect_word(input int src, input logic [DW-1:0] data);
    exp_q.push_back({SW'(src), data});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    m_ready = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 300) begin
      tick(1);
      n++;
    end
    check_output("drain_pending", exp_q.size(), 0);
  endtask

  // Source FIFO model: data appears the cycle after a read, empty updates after the edge.
  always @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (src_rd_en[i] && fifo_q[i].size() > 0) begin
        src_data[i*DW +: DW] <= fifo_q[i].pop_front();
      end
    end
    while (load_q.size() > 0) begin
      ld_word = load_q.pop_front();
      fifo_q[int'(ld_word[SW+DW-1:DW])].push_back(ld_word[DW-1:0]);
    end
    for (int i = 0; i < N_SRC; i++) begin
      src_empty[i] <= (fifo_q[i].size() == 0);
    end
  end

  // Monitor: scoreboard pops on every handshake; also checks read protocol and hold stability.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check_output("hold_valid", 32'(m_valid), 1);
        check_output("hold_word", 32'({m_src, m_data}), 32'(held_word));
      end
      if (src_rd_en != '0) begin
        check_output("rd_en_onehot", 32'($onehot(src_rd_en)), 1);
        check_output("rd_en_nonempty", 32'(|(src_rd_en & src_empty)), 0);
      end
      if (m_valid && m_ready) begin
        check_output("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check_output("out_word", 32'({m_src, m_data}), 32'(exp_word));
        end
      end
      held      = m_valid && !m_ready;
      held_word = {m_src, m_data};
    end
  end

  initial begin
    int first_v;
    int last_v;
    int n_v;
    int n;

    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b1;
    cfg_burst = 4'd4;
    tick(2);
    @(negedge clk);
    check_output("reset_m_valid", 32'(m_valid), 0);
    check_output("reset_m_data", 32'(m_data), 0);
    check_output("reset_m_src", 32'(m_src), 0);
    check_output("reset_rd_en", 32'(src_rd_en), 0);
    tick(1);
    rst = 1'b0;

    $display("[TB] single source burst shorter than cfg_burst");
    cfg_burst = 4'd4;
    apply_stimulus(1, 8'hA1); apply_stimulus(1, 8'hA2); apply_stimulus(1, 8'hA3);
    expect_word(1, 8'hA1); expect_word(1, 8'hA2); expect_word(1, 8'hA3);
    tick(1);
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_output($sformatf("t1_rd_en_%0d", k), 32'(src_rd_en), 32'(t1_rd[k]));
      check_output($sformatf("t1_valid_%0d", k), 32'(m_valid), 32'(t1_v[k]));
    end
    tick(1);
    wait_drain();

    $display("[TB] two sources, cfg_burst=2");
    do_reset();
    cfg_burst = 4'd2;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 8'h10 + 8'(k));
      apply_stimulus(2, 8'h20 + 8'(k));
    end
    expect_word(0, 8'h10); expect_word(0, 8'h11); expect_word(2, 8'h20); expect_word(2, 8'h21);
    expect_word(0, 8'h12); expect_word(0, 8'h13); expect_word(2, 8'h22); expect_word(2, 8'h23);
    tick(1);
    en = 1'b1;
    first_v = -1; last_v = -1; n_v = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        n_v++;
      end
    end
    check_output("t2_word_count", n_v, 8);
    check_output("t2_span", last_v - first_v + 1, 8);
    tick(1);
    wait_drain();

    $display("[TB] backpressure during a burst");
    do_reset();
    cfg_burst = 4'd8;
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1, 8'h30 + 8'(k));
      expect_word(1, 8'h30 + 8'(k));
    end
    tick(1);
    en = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("t3_first_valid_seen", 32'(m_valid), 1);
    tick(1);
    m_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_output($sformatf("t3_stall_valid_%0d", s), 32'(m_valid), 1);
      if (s >= 2) begin
        check_output($sformatf("t3_stall_rd_en_%0d", s), 32'(src_rd_en), 0);
      end
    end
    tick(1);
    m_ready = 1'b1;
    wait_drain();

    $display("[TB] round-robin wrap with cfg_burst=1");
    do_reset();
    cfg_burst = 4'd1;
    apply_stimulus(2, 8'h42);
    expect_word(2, 8'h42);
    tick(1);
    en = 1'b1;
    wait_drain();
    apply_stimulus(3, 8'h53); apply_stimulus(0, 8'h05);
    expect_word(3, 8'h53); expect_word(0, 8'h05);
    wait_drain();
    apply_stimulus(1, 8'h31); apply_stimulus(0, 8'h06);
    expect_word(1, 8'h31); expect_word(0, 8'h06);
    wait_drain();

    $display("[TB] cfg_burst=0 acts as one read per grant");
    do_reset();
    cfg_burst = 4'd0;
    apply_stimulus(0, 8'h60); apply_stimulus(0, 8'h61);
    apply_stimulus(1, 8'h70); apply_stimulus(1, 8'h71);
    expect_word(0, 8'h60); expect_word(1, 8'h70); expect_word(0, 8'h61); expect_word(1, 8'h71);
    tick(1);
    en = 1'b1;
    wait_drain();

    $display("[TB] reset in BURST with one queued and one in flight");
    do_reset();
    cfg_burst = 4'd4;
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(3, 8'h80 + 8'(k));
    end
    tick(1);
    en = 1'b1;
    tick(2);
    check_output("t6_pre_reset_valid", 32'(m_valid), 1);
    rst = 1'b1;
    en = 1'b0;
    tick(1);
    @(negedge clk);
    check_output("t6_reset_valid", 32'(m_valid), 0);
    check_output("t6_reset_rd_en", 32'(src_rd_en), 0);
    tick(1);
    rst = 1'b0;
    m_ready = 1'b1;
    apply_stimulus(0, 8'h07);
    expect_word(0, 8'h07); expect_word(3, 8'h82); expect_word(3, 8'h83);
    tick(1);
    en = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
